// File: rtl/song_reader_pkg.sv
// Shared widths, FSM state codes and ROM word layout for the song reader.
package song_reader_pkg;

    localparam int NOTES_PER_SONG_DEF = 32;
    localparam int NOTE_W_DEF         = 6;
    localparam int DUR_W_DEF          = 6;
    localparam int SONG_W             = 2;

    // ROM word: duration in the low bits, note code directly above it
    localparam int DUR_LSB = 0;

    function automatic int note_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FETCH   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_ISSUE   = 3'd3;
    localparam state_t ST_PLAYING = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/song_rom.sv
// Song table: synchronous-read memory addressed by {song, idx}, one-cycle read latency.
// The write port loads the table at bring-up; playback only reads it.
module song_rom #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the selected song's note list and hands notes to the note player.
// Build option SONG_READER_END_MARKER_EN: a zero-duration word ends the song early.
//
// state   | meaning
// IDLE    | paused or stopped; play=1 latches song and starts a fetch
// FETCH   | {cur_song, idx} presented to the song table
// WAIT    | table data valid; capture note/duration
// ISSUE   | new_note pulse to the note player
// PLAYING | waiting for note_done from the note player
// DONE    | song_done pulse, index rewinds to 0
module song_reader
    import song_reader_pkg::*;
#(
    parameter int NOTES_PER_SONG = NOTES_PER_SONG_DEF,
    parameter int NOTE_W         = NOTE_W_DEF,
    parameter int DUR_W          = DUR_W_DEF
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      play_i,
    input  logic                                      reset_player_i,
    input  logic [SONG_W-1:0]                         song_i,
    input  logic                                      note_done_i,
    input  logic                                      rom_wr_en_i,
    input  logic [SONG_W+$clog2(NOTES_PER_SONG)-1:0]  rom_wr_addr_i,
    input  logic [NOTE_W+DUR_W-1:0]                   rom_wr_data_i,
    output logic [NOTE_W-1:0]                         note_o,
    output logic [DUR_W-1:0]                          duration_o,
    output logic                                      new_note_o,
    output logic                                      song_done_o
);

    localparam int IDX_W    = $clog2(NOTES_PER_SONG);
    localparam int ADDR_W   = SONG_W + IDX_W;
    localparam int WORD_W   = NOTE_W + DUR_W;
    localparam int NOTE_LSB = note_lsb(DUR_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SONG_W-1:0]   cur_song_q, cur_song_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;

    logic [ADDR_W-1:0]   rom_addr;
    logic [WORD_W-1:0]   rom_data;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                restart;
    logic                end_marker;

    assign rom_addr = {cur_song_q, idx_q};
    assign rom_note = rom_data[NOTE_LSB +: NOTE_W];
    assign rom_dur  = rom_data[DUR_LSB +: DUR_W];

    // A song change while active behaves exactly like reset_player
    assign restart = reset_player_i || ((state_q != ST_IDLE) && (song_i != cur_song_q));

`ifdef SONG_READER_END_MARKER_EN
    assign end_marker = (rom_dur == '0);
`else
    assign end_marker = 1'b0;
`endif

    song_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_rom (
        .clk_i     (clk_i),
        .wr_en_i   (rom_wr_en_i),
        .wr_addr_i (rom_wr_addr_i),
        .wr_data_i (rom_wr_data_i),
        .rd_addr_i (rom_addr),
        .rd_data_o (rom_data)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cur_song_q <= '0;
            note_q     <= '0;
            dur_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_song_q <= cur_song_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_song_d = cur_song_q;
        note_d     = note_q;
        dur_d      = dur_q;
        if (restart) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            cur_song_d = song_i;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play_i) begin
                        cur_song_d = song_i;
                        state_d    = ST_FETCH;
                    end
                end
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (end_marker) begin
                        state_d = ST_DONE;
                    end else begin
                        note_d  = rom_note;
                        dur_d   = rom_dur;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: state_d = ST_PLAYING;
                ST_PLAYING: begin
                    if (note_done_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            // Pausing here parks on the next note so resume picks it up
                            idx_d   = idx_q + 1'b1;
                            state_d = play_i ? ST_FETCH : ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        new_note_o  = 1'b0;
        song_done_o = 1'b0;
        if (reset_i && !restart) begin
            new_note_o  = (state_q == ST_ISSUE);
            song_done_o = (state_q == ST_DONE);
        end
    end

    assign note_o     = note_q;
    assign duration_o = dur_q;

endmodule

// File: tb/tb_song_reader.sv
// Randomized bench for song_reader: random song table and note_done timing, checked
// against a note-position model (current song, current note index) kept in the bench.
module tb_song_reader;

    localparam int NPS = 32;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        play;
    logic        reset_player;
    logic [1:0]  song;
    logic        note_done;
    logic        rom_wr_en;
    logic [6:0]  rom_wr_addr;
    logic [11:0] rom_wr_data;
    logic [5:0]  note_o;
    logic [5:0]  duration_o;
    logic        new_note_o;
    logic        song_done_o;

    logic [11:0] rom_img [128];
    int n_checks = 0;
    int n_pass   = 0;
    int nn_cnt   = 0;
    int sd_cnt   = 0;
    int m_song;
    int m_idx;

    always #5 clk = ~clk;

    song_reader dut (
        .clk_i          (clk),
        .reset_i        (reset_b),
        .play_i         (play),
        .reset_player_i (reset_player),
        .song_i         (song),
        .note_done_i    (note_done),
        .rom_wr_en_i    (rom_wr_en),
        .rom_wr_addr_i  (rom_wr_addr),
        .rom_wr_data_i  (rom_wr_data),
        .note_o         (note_o),
        .duration_o     (duration_o),
        .new_note_o     (new_note_o),
        .song_done_o    (song_done_o)
    );

    always @(negedge clk) begin
        if (new_note_o) nn_cnt++;
        if (song_done_o) sd_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [11:0] word_of(input int s, input int i);
        return rom_img[s*NPS + i];
    endfunction

    // Optionally fires an extra note_done one cycle in, while the reader is fetching
    task automatic wait_new_note(input int max, input bit spurious, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            tick();
            note_done    = spurious && (c == 1);
            reset_player = 1'b0;
            if (new_note_o) begin
                lat = c;
                break;
            end
        end
        note_done = 1'b0;
    endtask

    task automatic wait_song_done(input int max, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            tick();
            note_done    = 1'b0;
            reset_player = 1'b0;
            if (song_done_o) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic expect_note(input string tag, input int exp_lat, input bit spurious);
        int lat;
        logic [11:0] w;
        w = word_of(m_song, m_idx);
        wait_new_note(40, spurious, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " note"}, 32'(note_o), 32'(w[11:6]));
        check({tag, " duration"}, 32'(duration_o), 32'(w[5:0]));
        tick();
        check({tag, " pulse width"}, 32'(new_note_o), 32'd0);
    endtask

    task automatic advance(input string tag, input bit spurious);
        repeat ($urandom_range(0, 3)) tick();
        note_done = 1'b1;
        m_idx++;
        expect_note(tag, 3, spurious);
    endtask

    initial begin
        int lat;
        int nn0;
        int sd0;
        logic [11:0] w;

        reset_b      = 1'b0;
        play         = 1'b0;
        reset_player = 1'b0;
        song         = 2'd0;
        note_done    = 1'b0;
        rom_wr_en    = 1'b0;
        rom_wr_addr  = '0;
        rom_wr_data  = '0;

        for (int a = 0; a < 128; a++) begin
            rom_img[a][11:6] = 6'($urandom_range(0, 63));
            rom_img[a][5:0]  = 6'($urandom_range(1, 63));
        end
        rom_img[0] = {6'd5, 6'd8};
        rom_img[2*NPS + 6][5:0] = 6'd0;

        // table is loaded while reset is held
        for (int a = 0; a < 128; a++) begin
            rom_wr_en   = 1'b1;
            rom_wr_addr = 7'(a);
            rom_wr_data = rom_img[a];
            tick();
        end
        rom_wr_en = 1'b0;
        check("in reset new_note", 32'(new_note_o), 32'd0);
        check("in reset song_done", 32'(song_done_o), 32'd0);

        reset_b = 1'b1;
        tick();
        check("after reset note", 32'(note_o), 32'd0);
        check("after reset duration", 32'(duration_o), 32'd0);
        check("after reset new_note", 32'(new_note_o), 32'd0);
        check("after reset song_done", 32'(song_done_o), 32'd0);
        repeat (10) tick();
        check("idle no new_note", 32'(nn_cnt), 32'd0);

        // first note: 3 cycles after play is sampled
        play   = 1'b1;
        m_song = 0;
        m_idx  = 0;
        expect_note("first note", 3, 1'b0);

        // whole song with play held high
        for (int i = 0; i < NPS; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            note_done = 1'b1;
            if (i < NPS - 1) begin
                m_idx++;
                expect_note("song0", 3, 1'($urandom_range(0, 1)));
            end else begin
                wait_song_done(10, lat);
                check("end of song song_done latency", 32'(lat), 32'd1);
            end
        end
        check("song0 new_note count", 32'(nn_cnt), 32'(NPS));
        check("song0 song_done count", 32'(sd_cnt), 32'd1);
        m_idx = 0;
        expect_note("restart after done", 4, 1'b0);
        check("single song_done", 32'(sd_cnt), 32'd1);

        // pause after note 3
        for (int k = 0; k < 3; k++) advance("to note3", 1'b0);
        play      = 1'b0;
        note_done = 1'b1;
        m_idx++;
        wait_new_note(20, 1'b0, lat);
        check("paused no new_note", 32'(lat), 32'hFFFF_FFFF);
        play = 1'b1;
        expect_note("resume", 3, 1'b0);

        // play drops while the next note is in flight: it is still issued
        note_done = 1'b1;
        m_idx++;
        tick();
        note_done = 1'b0;
        play      = 1'b0;
        expect_note("in flight", 2, 1'b0);
        note_done = 1'b1;
        m_idx++;
        wait_new_note(10, 1'b0, lat);
        check("paused again", 32'(lat), 32'hFFFF_FFFF);
        play = 1'b1;
        expect_note("resume again", 3, 1'b0);

        // random walk to note 10, then reset_player
        while (m_idx < 10) advance("random walk", 1'($urandom_range(0, 1)));
        sd0          = sd_cnt;
        reset_player = 1'b1;
        m_idx        = 0;
        expect_note("reset_player", 4, 1'b0);
        check("reset_player no song_done", 32'(sd_cnt), 32'(sd0));

        // song change mid-song
        repeat ($urandom_range(1, 4)) advance("pre change", 1'b0);
        song   = 2'd1;
        m_song = 1;
        m_idx  = 0;
        expect_note("song change", 4, 1'b0);
        check("song change no song_done", 32'(sd_cnt), 32'(sd0));

        // reset_player and note_done together
        repeat (2) advance("song1", 1'b0);
        reset_player = 1'b1;
        note_done    = 1'b1;
        m_idx        = 0;
        expect_note("reset_player beats note_done", 4, 1'b0);

        // song 2 has a zero-duration word at index 6
        song   = 2'd2;
        m_song = 2;
        m_idx  = 0;
        expect_note("song2", 4, 1'b0);
        for (int k = 0; k < 5; k++) advance("song2", 1'b0);
        sd0       = sd_cnt;
        nn0       = nn_cnt;
        note_done = 1'b1;
`ifdef SONG_READER_END_MARKER_EN
        w = word_of(2, 5);
        wait_song_done(10, lat);
        check("end marker song_done latency", 32'(lat), 32'd3);
        check("end marker no new_note", 32'(nn_cnt), 32'(nn0));
        check("end marker note held", 32'(note_o), 32'(w[11:6]));
        check("end marker duration held", 32'(duration_o), 32'(w[5:0]));
        play = 1'b0;
`else
        w = word_of(2, 6);
        m_idx++;
        expect_note("zero duration note", 3, 1'b0);
        check("zero duration issued", 32'(duration_o), 32'(w[5:0]));
        wait_new_note(6, 1'b0, lat);
        check("zero duration waits", 32'(lat), 32'hFFFF_FFFF);
        check("zero duration no song_done", 32'(sd_cnt), 32'(sd0));
        play = 1'b0;
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Player-side responder to the mcu play/next controller.
- Consumes play, reset_player and song[1:0]; walks the selected song's note list in a ROM; hands each note to the note player with a new_note pulse.
- Returns a one-cycle song_done pulse to the mcu when the song ends.

Parameters:
- NOTES_PER_SONG, 32, notes per song; power of two; sets the note index width IDX_W = log2(NOTES_PER_SONG).
- NOTE_W, 6, width of the note code field.
- DUR_W, 6, width of the duration field, in beats.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; 0 = reset.
- play  input  1  level from mcu; 1 = advance through song, 0 = paused.
- reset_player  input  1  from mcu; restart current song at note 0.
- song  input  2  song select from mcu.
- note_done  input  1  one-cycle pulse from note player: current note finished.
- note  output  NOTE_W  note code to note player, registered.
- duration  output  DUR_W  note length to note player, registered.
- new_note  output  1  one-cycle pulse: note/duration valid, start playing.
- song_done  output  1  one-cycle pulse to mcu: song finished.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, idx=0, note=0, duration=0, new_note=0, song_done=0, cur_song=0.
  - Reset overrides every other input.
- ROM address = {cur_song, idx}; synchronous read, 1-cycle latency.
- Word layout: {note[NOTE_W-1:0], duration[DUR_W-1:0]}.
- States:
  - IDLE: if play=1, latch cur_song<=song and go to FETCH; otherwise hold.
  - FETCH: address presented to the ROM; go to WAIT.
  - WAIT: ROM data valid; register note and duration; go to ISSUE.
  - ISSUE: new_note=1 for exactly this cycle; go to PLAYING.
  - PLAYING: wait for note_done.
    - On note_done with idx==NOTES_PER_SONG-1: go to DONE.
    - On note_done otherwise: idx<=idx+1 and go to FETCH, but only if play=1. If play=0, go to IDLE with the incremented idx, so the song resumes at the next note.
  - DONE: song_done=1 for exactly this cycle; idx<=0; go to IDLE.
- Latency: the edge that samples play=1 in IDLE is E0. new_note is high in the cycle after edge E2, i.e. 3 cycles from IDLE to ISSUE.
- Gap between notes: note_done sampled, then new_note for the next note 3 cycles later.
- Pause:
  - play=0 does not abort FETCH, WAIT or ISSUE; the in-flight note is issued.
  - In PLAYING, note_done is still honoured so the note player can finish the current note.
  - Resuming from IDLE continues at the stored idx.
- note_done outside PLAYING is ignored.
- reset_player=1 (priority below reset, above all else): idx<=0, state<=IDLE, cur_song<=song; no song_done; new_note forced 0 that cycle.
- Song change: song != cur_song in any non-IDLE state is treated exactly like reset_player.
- Wrap-around: idx never exceeds NOTES_PER_SONG-1; the end of song is the DONE path, never a silent wrap.
- Simultaneous reset_player and note_done: reset_player wins and idx=0.
- note and duration hold their last value between notes and during IDLE.

Optional Feature:
- Macro: SONG_READER_END_MARKER_EN.
- Defined: in WAIT, a ROM word with duration==0 is an end marker. Go directly to DONE; no new_note for it; note and duration keep their previous values.
- Not defined: all NOTES_PER_SONG words are played regardless of content. A zero-duration note is issued normally and the reader waits for note_done.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, FETCH, WAIT, ISSUE, PLAYING, DONE);
  - NOTE_W / DUR_W defaults;
  - the ROM word field offsets.
- One sub-module, song_rom: synchronous-read ROM, address {song, idx}, data NOTE_W+DUR_W. The bench can load it with known contents.

Test Plan:
- Reset low for 2 edges, then release → note=0, duration=0, new_note=0, song_done=0; no new_note while play=0 for 10 cycles.
- play=1, song=0, ROM[0]={note 5, dur 8} → new_note high exactly 3 cycles after play is sampled; note=5, duration=8; single-cycle pulse.
- Pulse note_done ×NOTES_PER_SONG with play held 1 → 32 new_note pulses; exactly one song_done, in the cycle after the final PLAYING; afterwards idx=0 and state IDLE.
- play=0 after note 3 is issued, then note_done → no new_note for 20 cycles. play=1 → next new_note carries ROM[{0,4}].
- Mid-song at note 10, pulse reset_player; separately change song 0→1 → no song_done; the next play yields ROM[{song,0}].
- With SONG_READER_END_MARKER_EN, ROM[{2,6}].duration=0 → song_done after the 6th note's note_done, with no 7th new_note. Without the macro → new_note issued with duration=0.
